rr_arbiter4: RTL and testbench
==============================

// Module: rr_arbiter4
// PURPOSE
//  Four-requester round-robin arbiter sharing one counter/datapath resource.
//  Rotating 2-bit priority pointer gives fair access; one requester owns the resource at a time.
//  Sits between requester blocks and the shared resource. gnt_onehot drives the resource mux select.
// PARAMETERS
//  MAX_HOLD   15  max consecutive grant cycles before forced release (timeout build only), 1..255
//  HOLD_W     8   width of hold counter; must satisfy 2**HOLD_W > MAX_HOLD
// PORTS
//  clk         in   1  rising-edge clock
//  rst         in   1  reset: synchronous, active-high
//  req         in   4  request per requester; level, held until served
//  gnt_onehot  out  4  registered one-hot grant; all-zero when idle
//  gnt_id      out  2  index of current grantee; valid only when busy=1
//  busy        out  1  1 while any grant is active
//  timeout     out  1  1-cycle pulse when a grant is forcibly revoked
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge): state=IDLE, ptr=2'd0, gnt_onehot=4'b0, gnt_id=2'd0,
//   busy=0, timeout=0, hold_cnt=0. rst overrides all other inputs, including mid-grant.
//  States: IDLE, GRANT.
//  IDLE: if |req, select first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4, 2-bit wrap);
//   next cycle: state=GRANT, gnt_onehot=1<<sel, gnt_id=sel, busy=1. If req==0, stay IDLE.
//  Latency: req sampled at edge k -> gnt visible after edge k+1 (one cycle, registered).
//  GRANT: hold while req[gnt_id]=1; other requests ignored (no preemption).
//  Release: req[gnt_id]=0 at an edge -> gnt cleared, busy=0, state=IDLE,
//   ptr <= gnt_id+1 (3 wraps to 0). Minimum one IDLE cycle between any two grants.
//  Requests arriving/dropping for non-granted indices during GRANT: no effect on state.
//  Simultaneous release and new requests: release wins that cycle; new grant arbitrated
//   next IDLE cycle from updated ptr.
//  Fairness: with all four req held, grant order 0,1,2,3,0... (build with timeout only,
//   since otherwise a requester holding req keeps the grant indefinitely).
//  gnt_onehot always one-hot or zero; gnt_id always equals encode(gnt_onehot) when busy.
//  hold_cnt: cleared on entering GRANT, +1 per GRANT cycle, saturates at MAX_HOLD.
// CONFIGURATION
//  Macro ARB_TIMEOUT_EN:
//   defined: when hold_cnt==MAX_HOLD-1 in GRANT and req[gnt_id] still 1, next edge forces
//    release exactly as normal release (ptr <= gnt_id+1) and pulses timeout=1 for one cycle.
//    Revoked requester must re-win arbitration; it is lowest priority next round.
//   undefined: no hold counter or limit logic; grant held until req drops; timeout tied 0.
// TESTING
//  T1 reset: rst=1 two cycles with req=4'b1111 -> gnt_onehot=0, busy=0, timeout=0 throughout.
//  T2 single: req=4'b0100 from IDLE, ptr=0 -> one cycle later gnt_onehot=4'b0100, gnt_id=2;
//     drop req[2] -> next cycle busy=0, then req[2] again regranted after 1 idle cycle.
//  T3 rotation: after grant to 1 released, req=4'b0011 -> grant to 0 skipped, ptr=2 so
//     scan 2,3,0 -> gnt_onehot=4'b0001; then release -> req[1] granted next (ptr=1).
//  T4 wrap: grant 3 released with req=4'b1001 -> ptr=0, gnt_onehot=4'b0001, not 4'b1000.
//  T5 mid-grant reset: grant active on id 2, assert rst one cycle -> gnt cleared next edge,
//     ptr=0; after rst low with req=4'b1111 -> grant id 0.
//  T6 timeout (ARB_TIMEOUT_EN, MAX_HOLD=4): req=4'b1111 held -> each grant lasts 4 cycles,
//     timeout pulses once per grant, order 0,1,2,3,0; without macro id 0 held for 100 cycles.

Source files
------------

// File: rtl/rr_arbiter4.sv
// ---------------------------------------------------------------------------
// rr_arbiter4 -- four-requester round-robin arbiter for one shared resource.
//
// A rotating 2-bit priority pointer picks the next grantee from IDLE; the
// grantee keeps the resource until it drops its request (no preemption).
// After every release the pointer moves to the index after the released
// grantee, so the released requester is lowest priority next round. There
// is always at least one IDLE cycle between two grants.
//
// Optional feature (macro ARB_TIMEOUT_EN):
//   defined   : a hold counter limits a grant to MAX_HOLD cycles; a grant
//               that reaches the limit is released as a normal release and
//               timeout pulses for one cycle.
//   undefined : no hold counter, grant held until the request drops,
//               timeout tied low.
//
// Parameters:
//   MAX_HOLD  max consecutive grant cycles (timeout build), 1..255
//   HOLD_W    hold counter width, 2**HOLD_W > MAX_HOLD
//
// Ports:
//   clk         in   1  rising-edge clock
//   rst         in   1  synchronous active-high reset, overrides everything
//   req         in   4  level request per requester, held until served
//   gnt_onehot  out  4  registered one-hot grant, zero when idle
//   gnt_id      out  2  index of current grantee, valid while busy
//   busy        out  1  a grant is active
//   timeout     out  1  one-cycle pulse after a forced release
//   dbg_state   out  1  FSM state (0 = IDLE, 1 = GRANT) for checkers
//
// Handshake: req is a level; a requester is served while req stays high and
// gnt_onehot has its bit set. Dropping req at an edge ends the grant at that
// same edge; the resource is free in the following cycle.
// ---------------------------------------------------------------------------
module rr_arbiter4 #(
  parameter int MAX_HOLD = 15,
  parameter int HOLD_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt_onehot,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       timeout,
  output logic       dbg_state
);

  // Parameter sanity checked at elaboration.
  if (MAX_HOLD < 1 || MAX_HOLD > 255 || (2 ** HOLD_W) <= MAX_HOLD) begin : g_bad_params
    $error("rr_arbiter4: illegal MAX_HOLD/HOLD_W combination");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] id_q, id_d;
  logic       timeout_q, timeout_d;

  // Round-robin scan result: first requester found from ptr upward (mod 4).
  logic [1:0] sel;
  logic       found;
  logic [1:0] idx;

  // Forced release request from the hold limiter (always 0 without it).
  logic       force_rel;

`ifdef ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
`endif

  always_comb begin
    sel   = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  assign force_rel = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));
`else
  assign force_rel = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    id_d      = id_q;
    timeout_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << sel;
          id_d    = sel;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
        end
      end
      GRANT: begin
        // Requests of other indices are ignored here; only the grantee's
        // request (or the hold limit) can end the grant.
        if (!req[id_q] || force_rel) begin
          state_d   = IDLE;
          gnt_d     = 4'b0000;
          ptr_d     = id_q + 2'd1;
          timeout_d = req[id_q];
        end else begin
`ifdef ARB_TIMEOUT_EN
          if (hold_cnt_q != HOLD_W'(MAX_HOLD)) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      gnt_q     <= 4'b0000;
      id_q      <= 2'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      id_q      <= id_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`endif

  assign gnt_onehot = gnt_q;
  assign gnt_id     = id_q;
  assign busy       = (state_q == GRANT);
  assign timeout    = timeout_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter4 -- directed bench for rr_arbiter4.
// Inputs change 1 ns after a rising edge; outputs are checked at that point,
// i.e. they reflect the state registered at the edge just passed.
// With ARB_TIMEOUT_EN defined the DUT is built with MAX_HOLD=4.
// ---------------------------------------------------------------------------
module tb_rr_arbiter4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt_onehot;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;
  logic       dbg_state;

  int n_checks;
  int n_fails;

  logic [1:0] exp_q[$];

  // -------------------------------------------------------------------------
  // Clock / DUT
  // -------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ARB_TIMEOUT_EN
  localparam int MAX_HOLD_TB = 4;
`else
  localparam int MAX_HOLD_TB = 15;
`endif

  rr_arbiter4 #(
    .MAX_HOLD(MAX_HOLD_TB),
    .HOLD_W  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt_onehot(gnt_onehot),
    .gnt_id    (gnt_id),
    .busy      (busy),
    .timeout   (timeout),
    .dbg_state (dbg_state)
  );

  // -------------------------------------------------------------------------
  // Driver / checking tasks
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Full output check while a grant is expected on id.
  task automatic check_grant(input string tag, input logic [1:0] id);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    check({tag, "_gnt"},  {4'b0, gnt_onehot}, {4'b0, oh});
    check({tag, "_id"},   {6'b0, gnt_id},     {6'b0, id});
    check({tag, "_busy"}, {7'b0, busy},       8'd1);
  endtask

  task automatic check_idle(input string tag, input logic exp_to);
    check({tag, "_gnt"},  {4'b0, gnt_onehot}, 8'd0);
    check({tag, "_busy"}, {7'b0, busy},       8'd0);
    check({tag, "_to"},   {7'b0, timeout},    {7'b0, exp_to});
  endtask

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b1;
    req = 4'b1111;

    // T1: reset held two cycles with all requests high.
    tick();
    check_idle("t1_rst_a", 1'b0);
    tick();
    check_idle("t1_rst_b", 1'b0);
    rst = 1'b0;
    req = 4'b0000;
    tick();
    check_idle("t1_idle", 1'b0);

    // T2: single requester 2 from ptr=0.
    req = 4'b0100;
    tick();
    check_grant("t2_grant", 2'd2);
    tick();
    check_grant("t2_hold", 2'd2);
    req = 4'b0000;
    tick();
    check_idle("t2_release", 1'b0);          // ptr now 3
    req = 4'b0100;
    tick();
    check_grant("t2_regrant", 2'd2);
    req = 4'b0000;
    tick();
    check_idle("t2_release2", 1'b0);         // ptr now 3

    // T3: rotation.
    req = 4'b0010;
    tick();
    check_grant("t3_g1", 2'd1);              // scan 3,0,1
    req = 4'b0000;
    tick();
    check_idle("t3_rel1", 1'b0);             // ptr now 2
    req = 4'b0011;
    tick();
    check_grant("t3_scan230", 2'd0);         // scan 2,3,0
    req = 4'b0010;
    tick();
    check_idle("t3_rel0", 1'b0);             // ptr now 1
    tick();
    check_grant("t3_g1_again", 2'd1);

    // Release and a new request at the same edge: release wins.
    req = 4'b1000;
    tick();
    check_idle("simul_rel", 1'b0);           // ptr now 2
    tick();
    check_grant("simul_next", 2'd3);

    // T4: wrap after grant 3.
    req = 4'b0000;
    tick();
    check_idle("t4_rel3", 1'b0);             // ptr wraps to 0
    req = 4'b1001;
    tick();
    check_grant("t4_wrap", 2'd0);

    // Other requests during a grant change nothing.
    req = 4'b1111;
    tick();
    check_grant("no_preempt", 2'd0);
    req = 4'b1110;
    tick();
    check_idle("rel0", 1'b0);                // ptr now 1
    tick();
    check_grant("after_rel0", 2'd1);
    req = 4'b0100;
    tick();
    check_idle("rel1", 1'b0);                // ptr now 2
    tick();
    check_grant("t5_setup", 2'd2);

    // T5: reset in the middle of a grant.
    rst = 1'b1;
    req = 4'b1111;
    tick();
    check_idle("t5_rst", 1'b0);
    rst = 1'b0;
    tick();
    check_grant("t5_after", 2'd0);           // ptr back to 0

    // T6: all four requests held.
`ifdef ARB_TIMEOUT_EN
    exp_q = {2'd1, 2'd2, 2'd3, 2'd0};
    begin
      logic [1:0] cur;
      logic [1:0] nxt;
      int         pulses;
      cur    = 2'd0;
      pulses = 0;
      for (int g = 0; g < 4; g++) begin
        for (int c = 1; c < MAX_HOLD_TB; c++) begin
          tick();
          check_grant("t6_hold", cur);
          check("t6_hold_to", {7'b0, timeout}, 8'd0);
        end
        tick();
        check_idle("t6_forced", 1'b1);
        if (timeout === 1'b1) pulses++;
        nxt = exp_q.pop_front();
        tick();
        check_grant("t6_next", nxt);
        check("t6_next_to", {7'b0, timeout}, 8'd0);
        cur = nxt;
      end
      check("t6_pulses", 8'(pulses), 8'd4);
      check("t6_queue_empty", 8'(exp_q.size()), 8'd0);
    end
`else
    begin
      int lost;
      lost = 0;
      for (int c = 0; c < 100; c++) begin
        tick();
        if (gnt_onehot !== 4'b0001 || gnt_id !== 2'd0 || busy !== 1'b1 || timeout !== 1'b0)
          lost++;
      end
      check("t6_held_100", 8'(lost), 8'd0);
      check_grant("t6_end", 2'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
